// File: rtl/route_input_conditioner_if.sv
// Bus between the route input conditioner and its environment: raw pins,
// per-channel edge/filter configuration, conditioned pulses and levels.
// Optional holdoff_len signal exists only when ROUTE_INPUT_HOLDOFF_EN is defined.
interface route_input_conditioner_if #(
  parameter int unsigned NUM_ROUTES   = 16,
  parameter int unsigned FILTER_WIDTH = 8
);
  logic [NUM_ROUTES-1:0]   pin_in;
  logic [NUM_ROUTES-1:0]   edge_rise;
  logic [NUM_ROUTES-1:0]   edge_fall;
  logic [FILTER_WIDTH-1:0] filter_len;
`ifdef ROUTE_INPUT_HOLDOFF_EN
  logic [FILTER_WIDTH-1:0] holdoff_len;
`endif
  logic [NUM_ROUTES-1:0]   route_out;
  logic [NUM_ROUTES-1:0]   level_out;
  logic                    priming;

  // Environment side: drives pins and configuration, observes results
  modport master (
`ifdef ROUTE_INPUT_HOLDOFF_EN
    output holdoff_len,
`endif
    output pin_in, edge_rise, edge_fall, filter_len,
    input  route_out, level_out, priming
  );

  // Conditioner side
  modport slave (
`ifdef ROUTE_INPUT_HOLDOFF_EN
    input  holdoff_len,
`endif
    input  pin_in, edge_rise, edge_fall, filter_len,
    output route_out, level_out, priming
  );
endinterface

// File: rtl/route_input_conditioner.sv
// Route input conditioner: synchronises raw event pins into ctrclk, qualifies
// each channel with a consecutive-sample glitch filter and emits one-cycle
// trigger pulses on enabled rise/fall transitions.
// Optional feature macro: ROUTE_INPUT_HOLDOFF_EN (per-channel pulse holdoff).
module route_input_conditioner #(
  parameter int unsigned NUM_ROUTES   = 16,
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic                      ctrclk,
  input logic                      ctrrst,
  route_input_conditioner_if.slave bus
);

  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

  typedef enum logic [1:0] {STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO} chan_state_t;
  typedef enum logic {PRIME, RUN} phase_t;

  logic [NUM_ROUTES-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_ROUTES-1:0]   s;
  chan_state_t             state_q [NUM_ROUTES];
  chan_state_t             state_d [NUM_ROUTES];
  logic [FILTER_WIDTH-1:0] cnt_q   [NUM_ROUTES];
  logic [FILTER_WIDTH-1:0] cnt_d   [NUM_ROUTES];
  phase_t                  phase_q, phase_d;
  logic [PRIME_W-1:0]      prime_cnt_q, prime_cnt_d;
  logic [NUM_ROUTES-1:0]   route_q, route_d;
  logic [NUM_ROUTES-1:0]   level_q, level_d;
  logic [NUM_ROUTES-1:0]   fire;
`ifdef ROUTE_INPUT_HOLDOFF_EN
  logic [FILTER_WIDTH-1:0] hold_q [NUM_ROUTES];
  logic [FILTER_WIDTH-1:0] hold_d [NUM_ROUTES];
`endif

  // Filtered level encoded by a channel state
  function automatic logic is_hi(input chan_state_t st);
    return (st == STABLE_HI) || (st == QUAL_LO);
  endfunction

  assign s             = sync_q[SYNC_STAGES-1];
  assign bus.route_out = route_q;
  assign bus.level_out = level_q;
  assign bus.priming   = (phase_q == PRIME);

  // State registers: synchroniser chain, channel FSMs, priming phase, outputs
  always_ff @(posedge ctrclk) begin
    if (ctrrst) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      for (int i = 0; i < NUM_ROUTES; i++) begin
        state_q[i] <= STABLE_LO;
        cnt_q[i]   <= '0;
`ifdef ROUTE_INPUT_HOLDOFF_EN
        hold_q[i]  <= '0;
`endif
      end
      phase_q     <= PRIME;
      prime_cnt_q <= '0;
      route_q     <= '0;
      level_q     <= '0;
    end else begin
      sync_q[0] <= bus.pin_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef ROUTE_INPUT_HOLDOFF_EN
      hold_q      <= hold_d;
`endif
      phase_q     <= phase_d;
      prime_cnt_q <= prime_cnt_d;
      route_q     <= route_d;
      level_q     <= level_d;
    end
  end

  // Next-state: priming loads the current synchronised level, then qualify
  always_comb begin
    phase_d     = phase_q;
    prime_cnt_d = prime_cnt_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    route_d     = '0;
    level_d     = level_q;
    fire        = '0;
`ifdef ROUTE_INPUT_HOLDOFF_EN
    hold_d      = hold_q;
`endif

    if (phase_q == PRIME) begin
      prime_cnt_d = prime_cnt_q + PRIME_W'(1);
      if (prime_cnt_q == PRIME_LAST) phase_d = RUN;
      for (int i = 0; i < NUM_ROUTES; i++) begin
        state_d[i] = s[i] ? STABLE_HI : STABLE_LO;
        cnt_d[i]   = '0;
      end
    end else begin
      for (int i = 0; i < NUM_ROUTES; i++) begin
        if (s[i] == is_hi(state_q[i])) begin
          // Matching sample: settle (a glitch under qualification is dropped)
          state_d[i] = s[i] ? STABLE_HI : STABLE_LO;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] >= bus.filter_len) begin
          state_d[i] = s[i] ? STABLE_HI : STABLE_LO;
          cnt_d[i]   = '0;
          fire[i]    = s[i] ? bus.edge_rise[i] : bus.edge_fall[i];
        end else begin
          state_d[i] = s[i] ? QUAL_HI : QUAL_LO;
          cnt_d[i]   = cnt_q[i] + FILTER_WIDTH'(1);
        end
      end
    end

    for (int i = 0; i < NUM_ROUTES; i++) level_d[i] = is_hi(state_d[i]);

`ifdef ROUTE_INPUT_HOLDOFF_EN
    // Holdoff: drop qualified pulses while the channel counter is nonzero
    for (int i = 0; i < NUM_ROUTES; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - FILTER_WIDTH'(1) : '0;
      if (fire[i] && (hold_q[i] == '0)) begin
        route_d[i] = 1'b1;
        hold_d[i]  = bus.holdoff_len;
      end
    end
`else
    route_d = fire;
`endif
  end

endmodule

// File: tb/tb_route_input_conditioner.sv
// Directed self-checking bench for route_input_conditioner.
// Holdoff scenario is compiled only with ROUTE_INPUT_HOLDOFF_EN.
module tb_route_input_conditioner;

  logic clk;
  logic ctrrst;
  int   total;
  int   bad;

  route_input_conditioner_if #(.NUM_ROUTES(16), .FILTER_WIDTH(8)) bus ();

  route_input_conditioner #(
    .NUM_ROUTES(16), .FILTER_WIDTH(8), .SYNC_STAGES(2)
  ) dut (
    .ctrclk (clk),
    .ctrrst (ctrrst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, land 1 time unit after the last
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef ROUTE_INPUT_HOLDOFF_EN
  logic hist [0:127];
  int   last_pulse;
  int   npulse;
`endif

  initial begin
    total = 0;
    bad   = 0;
    ctrrst         = 1'b1;
    bus.pin_in     = 16'h0001;
    bus.edge_rise  = 16'hffff;
    bus.edge_fall  = 16'h0000;
    bus.filter_len = 8'd0;
`ifdef ROUTE_INPUT_HOLDOFF_EN
    bus.holdoff_len = 8'd0;
`endif

    // Reset state, pin 0 already high
    step(2);
    chk("rst_priming", 16'(bus.priming), 16'h0001);
    chk("rst_route", bus.route_out, 16'h0000);
    chk("rst_level", bus.level_out, 16'h0000);
    ctrrst = 1'b0;
    step(1);
    chk("prime1", 16'(bus.priming), 16'h0001);
    step(1);
    chk("prime2", 16'(bus.priming), 16'h0001);
    step(1);
    chk("prime_done", 16'(bus.priming), 16'h0000);
    chk("prime_level", bus.level_out, 16'h0001);
    chk("prime_route", bus.route_out, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("no_spurious_rise", bus.route_out, 16'h0000);
    end

    // filter_len=0 rise on pin 3: pulse 3 edges later
    bus.pin_in[3] = 1'b1;
    step(2);
    chk("r3_early", bus.route_out, 16'h0000);
    step(1);
    chk("r3_pulse", bus.route_out, 16'h0008);
    chk("r3_level", bus.level_out, 16'h0009);
    step(1);
    chk("r3_single", bus.route_out, 16'h0000);
    // fall with edge_fall disabled: level follows, no pulse
    bus.pin_in[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("r3_fall_nopulse", bus.route_out, 16'h0000);
    end
    chk("r3_fall_level", bus.level_out, 16'h0001);

    // filter_len=4: 4-cycle glitch rejected, 5-cycle hold qualifies at k+7
    bus.filter_len = 8'd4;
    bus.pin_in[5]  = 1'b1;
    step(4);
    bus.pin_in[5]  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("f5_glitch", bus.route_out, 16'h0000);
    end
    chk("f5_glitch_level", bus.level_out, 16'h0001);
    bus.pin_in[5] = 1'b1;
    step(6);
    chk("f5_early", bus.route_out, 16'h0000);
    step(1);
    chk("f5_pulse", bus.route_out, 16'h0020);
    chk("f5_level", bus.level_out, 16'h0021);
    step(1);
    chk("f5_single", bus.route_out, 16'h0000);

    // Fall-only on pin 7, filter_len=2: one pulse 5 edges after the fall
    bus.edge_rise  = 16'h0000;
    bus.edge_fall  = 16'h0080;
    bus.filter_len = 8'd2;
    bus.pin_in[7]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("p7_rise_nopulse", bus.route_out, 16'h0000);
    end
    chk("p7_hi_level", bus.level_out, 16'h00a1);
    bus.pin_in[7] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      chk("p7_fall_early", bus.route_out, 16'h0000);
    end
    step(1);
    chk("p7_fall_pulse", bus.route_out, 16'h0080);
    chk("p7_fall_level", bus.level_out, 16'h0021);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("p7_after", bus.route_out, 16'h0000);
    end

    // All 16 rise together, filter_len=1: 16'hffff once, 4 edges later
    bus.edge_fall  = 16'h0000;
    bus.pin_in     = 16'h0000;
    step(10);
    chk("all_low_level", bus.level_out, 16'h0000);
    bus.edge_rise  = 16'hffff;
    bus.filter_len = 8'd1;
    bus.pin_in     = 16'hffff;
    step(3);
    chk("all_early", bus.route_out, 16'h0000);
    step(1);
    chk("all_pulse", bus.route_out, 16'hffff);
    chk("all_level", bus.level_out, 16'hffff);
    step(1);
    chk("all_single", bus.route_out, 16'h0000);

    // Rerun with reset landing on the qualifying edge: no pulse at all
    bus.pin_in = 16'h0000;
    step(10);
    bus.pin_in = 16'hffff;
    step(3);
    ctrrst = 1'b1;
    step(1);
    chk("mid_rst_route", bus.route_out, 16'h0000);
    chk("mid_rst_priming", 16'(bus.priming), 16'h0001);
    chk("mid_rst_level", bus.level_out, 16'h0000);
    ctrrst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      chk("mid_rst_nopulse", bus.route_out, 16'h0000);
    end
    chk("mid_rst_primed_level", bus.level_out, 16'hffff);
    chk("mid_rst_primed", 16'(bus.priming), 16'h0000);

    // Lowering filter_len below a running count qualifies on next sample
    bus.edge_fall  = 16'h0004;
    bus.filter_len = 8'd10;
    bus.pin_in[2]  = 1'b0;
    step(8);
    chk("lower_early", bus.route_out, 16'h0000);
    bus.filter_len = 8'd2;
    step(1);
    chk("lower_pulse", bus.route_out, 16'h0004);
    chk("lower_level", bus.level_out, 16'hfffb);
    step(1);
    chk("lower_single", bus.route_out, 16'h0000);

`ifdef ROUTE_INPUT_HOLDOFF_EN
    // Holdoff 10 with pin 1 toggling every 4 cycles, both edges enabled
    bus.holdoff_len = 8'd10;
    bus.filter_len  = 8'd0;
    bus.edge_rise   = 16'h0002;
    bus.edge_fall   = 16'h0002;
    last_pulse      = 0;
    npulse          = 0;
    for (int c = 0; c < 80; c++) begin
      if ((c % 4) == 0) bus.pin_in[1] = ~bus.pin_in[1];
      hist[c] = bus.pin_in[1];
      step(1);
      if (c >= 2) chk("hold_level", 16'(bus.level_out[1]), 16'(hist[c-2]));
      if (bus.route_out[1]) begin
        if (npulse > 0) chk("hold_spacing", 16'((c - last_pulse) >= 11), 16'h0001);
        last_pulse = c;
        npulse++;
      end
    end
    chk("hold_pulses_seen", 16'(npulse >= 2), 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/route_input_conditioner.md
Name: route_input_conditioner

Overview:
- Conditions raw external or asynchronous event pins into clean, single-cycle trigger pulses in the counter clock domain.
- Its route_out bus drives the route_in bus of the counter blocks directly.
- Per-channel functions: synchroniser, glitch filter (consecutive-sample qualifier), and rise/fall edge selection.
- Configuration inputs are quasi-static and come from registers already in the ctrclk domain.

Parameters:
- NUM_ROUTES, 16: number of channels; must match the counter block route width.
- FILTER_WIDTH, 8: width of filter_len and of each per-channel qualifier counter.
- SYNC_STAGES, 2: synchroniser flop depth per channel; minimum 2.

Ports:
- ctrclk  in  1  sole clock; all state updates on its rising edge.
- ctrrst  in  1  reset, synchronous, active-high.
- pin_in  in  NUM_ROUTES  raw asynchronous event inputs.
- edge_rise  in  NUM_ROUTES  per channel: emit a pulse on a qualified low->high transition.
- edge_fall  in  NUM_ROUTES  per channel: emit a pulse on a qualified high->low transition.
- filter_len  in  FILTER_WIDTH  number of extra consecutive differing samples required; shared by all channels.
- route_out  out  NUM_ROUTES  registered one-cycle trigger pulses.
- level_out  out  NUM_ROUTES  registered filtered (stable) level of each channel.
- priming  out  1  high while the post-reset priming phase is active.

Behaviour:
- Clock and reset: one clock, ctrclk. Reset ctrrst is synchronous and active-high.
- Reset values: sync chain=0, stable=0, qualifier cnt=0, route_out=0, level_out=0, priming=1, prime counter=0.
- Synchroniser: s[i] is the output of the last sync stage for pin_in[i].
- Priming phase:
  - Lasts SYNC_STAGES+1 cycles after ctrrst deasserts.
  - Each cycle: stable<=s, cnt<=0, route_out=0.
  - Then priming<=0.
  - Purpose: a pin already high at reset produces no spurious rise pulse.
- Per channel, every cycle after priming:
  - s==stable: cnt<=0, route_out[i]<=0.
  - s!=stable and cnt>=filter_len:
    - stable<=s, cnt<=0.
    - route_out[i]<=(s ? edge_rise[i] : edge_fall[i]).
  - s!=stable and cnt<filter_len: cnt<=cnt+1, route_out[i]<=0.
- Equivalent per-channel state machine: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
  - A QUAL state returns to its STABLE state on any matching sample (glitch rejected, cnt cleared).
- Latency: a pin change held steady from edge k shows on route_out after edge k+SYNC_STAGES+1+filter_len.
  - SYNC_STAGES=2, filter_len=0: 3 cycles.
- Pulse width: route_out is high for exactly one cycle per qualified transition.
  - No pulse for a transition whose edge enable is 0; level_out still follows.
- Wrap-around: cnt saturates via the >= compare and never wraps.
  - Lowering filter_len while cnt is larger qualifies on the next differing sample.
- Config timing: edge_rise, edge_fall and filter_len are sampled in the qualifying cycle only.
  - Changes mid-qualification take effect immediately; no pulse is lost or duplicated.
- Simultaneous events: channels are fully independent.
  - Any number of route_out bits may assert in the same cycle.
- Reset mid-operation: ctrrst at any cycle discards pending qualification and re-enters priming.
  - No pulse is emitted in the reset cycle or during priming.
- Width rules: filter_len is unsigned.
  - Maximum filter delay is 2^FILTER_WIDTH-1 extra samples.

Optional Feature:
- Macro: ROUTE_INPUT_HOLDOFF_EN.
- Defined:
  - Adds input port holdoff_len (FILTER_WIDTH bits) and a per-channel holdoff down-counter.
  - After a route_out pulse on channel i, further pulses on i are suppressed for holdoff_len cycles.
  - stable and level_out keep tracking during holdoff. Suppressed transitions are dropped, not queued.
  - holdoff_len=0 behaves exactly as the feature-absent build.
  - Holdoff counters clear on ctrrst.
- Undefined: no holdoff_len port, no holdoff counters; every qualified enabled transition pulses.

Test Plan:
- Reset with pin_in[0]=1, edge_rise=all ones -> priming high for 3 cycles, then level_out[0]=1, route_out stays 0.
- filter_len=0, edge_rise[3]=1, pin_in[3] 0->1 at edge k -> route_out[3] single pulse after edge k+3; level_out[3]=1 same cycle.
- filter_len=4, pin_in[5] high for 4 cycles then low -> no pulse, level_out[5] stays 0. Held high 5 cycles -> one pulse at k+7.
- edge_rise=0, edge_fall[7]=1, pin_in[7] 0->1->0 (each held 10 cycles, filter_len=2) -> exactly one pulse, on the fall, 5 cycles after it.
- All 16 pins rise at once, edge_rise=all ones, filter_len=1 -> route_out=16'hffff for exactly one cycle, 4 cycles later. Assert ctrrst during qualification in a rerun -> no pulse.
- With ROUTE_INPUT_HOLDOFF_EN, holdoff_len=10, filter_len=0, pin_in[1] toggles every 4 cycles, both edges enabled -> pulses spaced at least 11 cycles apart; level_out[1] follows every toggle.
